// File: rtl/capi_tag_client_pkg.sv
// rtl/capi_tag_client_pkg.sv - shared helpers for the tag client slice
package capi_tag_client_pkg;

  // Table address width: the parity bit, when present, is not part of the index.
  function automatic int tag_aw(input int id_width, input int parity);
    return id_width - parity;
  endfunction

endpackage

// File: rtl/base_incdec.sv
// rtl/base_incdec.sv - saturating up/down counter, simultaneous inc+dec holds
module base_incdec #(
  parameter int width = 5,
  parameter int max   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [width-1:0] cnt
);
  localparam logic [width-1:0] max_v = width'(max);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (cnt != max_v) cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/base_vlat_sr.sv
// rtl/base_vlat_sr.sv - sticky set/clear flag
module base_vlat_sr (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset)    q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

// File: rtl/capi_parcheck.sv
// rtl/capi_parcheck.sv - odd-parity checker, flags err when enabled and parity is even
module capi_parcheck #(
  parameter int width = 4
) (
  input  logic             en,
  input  logic [width-1:0] data,
  output logic             err
);
  assign err = en & ~(^data);
endmodule

// File: rtl/capi_tag_ctx_table.sv
// rtl/capi_tag_ctx_table.sv - per-tag context array and outstanding bit vector
module capi_tag_ctx_table #(
  parameter int aw        = 4,
  parameter int ctx_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set,
  input  logic [aw-1:0]        set_addr,
  input  logic [ctx_width-1:0] set_ctx,
  input  logic                 rd_clr,
  input  logic [aw-1:0]        rd_addr,
  output logic [ctx_width-1:0] rd_ctx,
  output logic                 rd_bit
);
  localparam int depth = 1 << aw;

  logic [ctx_width-1:0] ctx_mem [depth];
  logic [depth-1:0]     out_bits;

  assign rd_ctx = ctx_mem[rd_addr];
  assign rd_bit = out_bits[rd_addr];

  always_ff @(posedge clk) begin
    if (set) ctx_mem[set_addr] <= set_ctx;
  end

  // Set is applied after clear so a same-tag issue re-arms the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_bits <= '0;
    end else begin
      if (rd_clr && rd_bit) out_bits[rd_addr] <= 1'b0;
      if (set) out_bits[set_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/capi_tag_client.sv
// rtl/capi_tag_client.sv - joins requests with pool tags, tracks context, completes and frees tags
module capi_tag_client
  import capi_tag_client_pkg::*;
#(
  parameter int parity    = 0,
  parameter int id_width  = 4,
  parameter int ctx_width = 16,
  parameter int sts_width = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_req_v,
  output logic                       i_req_r,
  input  logic [ctx_width-1:0]       i_req_ctx,
  input  logic                       i_tag_v,
  output logic                       i_tag_r,
  input  logic [id_width-1:0]        i_tag_id,
  output logic                       o_cmd_v,
  input  logic                       o_cmd_r,
  output logic [id_width-1:0]        o_cmd_tag,
  output logic [ctx_width-1:0]       o_cmd_ctx,
  input  logic                       i_rsp_v,
  output logic                       i_rsp_r,
  input  logic [id_width-1:0]        i_rsp_tag,
  input  logic [sts_width-1:0]       i_rsp_sts,
  output logic                       o_cpl_v,
  input  logic                       o_cpl_r,
  output logic [ctx_width-1:0]       o_cpl_ctx,
  output logic [sts_width-1:0]       o_cpl_sts,
  output logic                       o_free_v,
  output logic [id_width-1:0]        o_free_id,
  output logic                       o_rsp_err,
  output logic [id_width-parity:0]   o_cnt,
  output logic                       o_perror
);
  localparam int aw       = tag_aw(id_width, parity);
  localparam int num_tags = 1 << aw;

  logic                 issue_go, rsp_go, cpl_go;
  logic                 s1_v;
  logic [id_width-1:0]  s1_tag;
  logic [ctx_width-1:0] s1_ctx;
  logic [sts_width-1:0] s1_sts;
  logic [ctx_width-1:0] rd_ctx;
  logic                 rd_bit;
  logic                 tag_perr, rsp_perr, perr_lat;

  // Request and tag are consumed together or not at all.
  assign o_cmd_v   = ~reset & i_req_v & i_tag_v;
  assign issue_go  = o_cmd_v & o_cmd_r;
  assign i_req_r   = issue_go;
  assign i_tag_r   = issue_go;
  assign o_cmd_tag = reset ? '0 : i_tag_id;
  assign o_cmd_ctx = reset ? '0 : i_req_ctx;

  assign i_rsp_r   = ~reset & (~s1_v | o_cpl_r);
  assign rsp_go    = i_rsp_v & i_rsp_r;
  assign cpl_go    = s1_v & o_cpl_r;
  assign o_cpl_v   = s1_v;
  assign o_cpl_ctx = s1_ctx;
  assign o_cpl_sts = s1_sts;

  capi_tag_ctx_table #(.aw(aw), .ctx_width(ctx_width)) u_table (
    .clk      (clk),
    .reset    (reset),
    .set      (issue_go),
    .set_addr (i_tag_id[id_width-1:parity]),
    .set_ctx  (i_req_ctx),
    .rd_clr   (rsp_go),
    .rd_addr  (i_rsp_tag[id_width-1:parity]),
    .rd_ctx   (rd_ctx),
    .rd_bit   (rd_bit)
  );

  // Single-entry response latch; a miss never occupies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_tag    <= '0;
      s1_ctx    <= '0;
      s1_sts    <= '0;
      o_rsp_err <= 1'b0;
      o_free_v  <= 1'b0;
      o_free_id <= '0;
      o_perror  <= 1'b0;
    end else begin
      o_rsp_err <= rsp_go & ~rd_bit;
      o_free_v  <= cpl_go;
      o_free_id <= s1_tag;
      o_perror  <= perr_lat;
      if (rsp_go) begin
        s1_v   <= rd_bit;
        s1_tag <= i_rsp_tag;
        s1_ctx <= rd_ctx;
        s1_sts <= i_rsp_sts;
      end else if (cpl_go) begin
        s1_v <= 1'b0;
      end
    end
  end

  base_incdec #(.width(aw + 1), .max(num_tags)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (issue_go),
    .dec   (cpl_go),
    .cnt   (o_cnt)
  );

  capi_parcheck #(.width(id_width)) u_pc_tag (
    .en   ((parity != 0) && issue_go),
    .data (i_tag_id),
    .err  (tag_perr)
  );

  capi_parcheck #(.width(id_width)) u_pc_rsp (
    .en   ((parity != 0) && rsp_go),
    .data (i_rsp_tag),
    .err  (rsp_perr)
  );

  base_vlat_sr u_perr (
    .clk   (clk),
    .reset (reset),
    .set   (tag_perr | rsp_perr),
    .clr   (1'b0),
    .q     (perr_lat)
  );
endmodule
